// File: rtl/axi_lite_mult_slave.sv
// AXI4-Lite slave wrapping a shift-add multiplier (OPA, OPB, CTRL/STATUS, RESULT).
// Define AXI_LITE_MULT_SIGNED_EN for two's-complement operands and a sign-extended RESULT.
module axi_lite_mult_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  parameter int OP_WIDTH           = 16
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic                            mult_done_o,
  output logic                            mult_state_o
);

  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int PW = 2 * OP_WIDTH;
  localparam int CW = $clog2(OP_WIDTH + 1);

  // Handshakes: a transfer happens on a rising edge where VALID and READY are both
  // high. AWREADY/WREADY pulse together once both valids are seen and no response is
  // pending; ARREADY pulses once per read while no read data is pending. BVALID and
  // RVALID rise the cycle after their handshake and hold (with RDATA stable) until
  // the master's READY is sampled high.

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  logic          wr_ready_q, bvalid_q, rd_ready_q, rvalid_q;
  logic [DW-1:0] rdata_q, rd_mux;
  logic [DW-1:0] opa_q, opb_q, result_q, result_d, result_fix;
  logic          done_q, done_d;
  state_t        state_q, state_d;
  logic [PW-1:0] mcand_q, mcand_d, acc_q, acc_d;
  logic [OP_WIDTH-1:0] mplier_q, mplier_d, opa_lo, opb_lo, a_mag, b_mag;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          wr_hs, rd_hs, ctrl_wr, start_req, clr_req, start_accept;
  logic [1:0]    wr_sel, rd_sel;
  logic          unused_ok;

  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  assign wr_hs  = wr_ready_q & S_AXI_AWVALID & S_AXI_WVALID;
  assign rd_hs  = rd_ready_q & S_AXI_ARVALID;
  assign wr_sel = S_AXI_AWADDR[3:2];
  assign rd_sel = S_AXI_ARADDR[3:2];

  assign ctrl_wr      = wr_hs & (wr_sel == 2'd2) & S_AXI_WSTRB[0];
  assign start_req    = ctrl_wr & S_AXI_WDATA[0];
  assign clr_req      = ctrl_wr & S_AXI_WDATA[1];
  assign start_accept = start_req & (state_q == S_IDLE);

  assign S_AXI_AWREADY = wr_ready_q;
  assign S_AXI_WREADY  = wr_ready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = 2'b00;
  assign S_AXI_ARREADY = rd_ready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = 2'b00;
  assign mult_done_o   = done_q;
  assign mult_state_o  = (state_q == S_RUN);

  function automatic logic [DW-1:0] apply_strb(input logic [DW-1:0] old_v,
                                               input logic [DW-1:0] new_v,
                                               input logic [DW/8-1:0] strb);
    logic [DW-1:0] r;
    r = old_v;
    for (int i = 0; i < DW / 8; i++) begin
      if (strb[i]) r[8*i +: 8] = new_v[8*i +: 8];
    end
    return r;
  endfunction

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      wr_ready_q <= 1'b0;
      bvalid_q   <= 1'b0;
    end else begin
      wr_ready_q <= S_AXI_AWVALID & S_AXI_WVALID & ~wr_ready_q & ~bvalid_q;
      if (wr_hs)             bvalid_q <= 1'b1;
      else if (S_AXI_BREADY) bvalid_q <= 1'b0;
    end
  end

  // OPA/OPB stay writable while a multiply runs; the FSM keeps its own copies.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      opa_q <= '0;
      opb_q <= '0;
    end else if (wr_hs) begin
      if (wr_sel == 2'd0) opa_q <= apply_strb(opa_q, S_AXI_WDATA, S_AXI_WSTRB);
      if (wr_sel == 2'd1) opb_q <= apply_strb(opb_q, S_AXI_WDATA, S_AXI_WSTRB);
    end
  end

  always_comb begin
    rd_mux = '0;
    case (rd_sel)
      2'd0:    rd_mux = opa_q;
      2'd1:    rd_mux = opb_q;
      2'd2:    rd_mux = {{(DW-2){1'b0}}, done_q, (state_q == S_RUN)};
      default: rd_mux = result_q;
    endcase
  end

  // rd_mux sees pre-edge register values, so a same-cycle write is not observed.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      rd_ready_q <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
    end else begin
      rd_ready_q <= S_AXI_ARVALID & ~rd_ready_q & ~rvalid_q;
      if (rd_hs) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rd_mux;
      end else if (S_AXI_RREADY) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  assign opa_lo = opa_q[OP_WIDTH-1:0];
  assign opb_lo = opb_q[OP_WIDTH-1:0];

`ifdef AXI_LITE_MULT_SIGNED_EN
  logic          neg_q;
  logic [PW-1:0] prod_fix;

  assign a_mag    = opa_lo[OP_WIDTH-1] ? (~opa_lo + 1'b1) : opa_lo;
  assign b_mag    = opb_lo[OP_WIDTH-1] ? (~opb_lo + 1'b1) : opb_lo;
  assign prod_fix = neg_q ? (~acc_q + 1'b1) : acc_q;
  assign result_fix = DW'($signed(prod_fix));

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN)    neg_q <= 1'b0;
    else if (start_accept) neg_q <= opa_lo[OP_WIDTH-1] ^ opb_lo[OP_WIDTH-1];
  end
`else
  assign a_mag      = opa_lo;
  assign b_mag      = opb_lo;
  assign result_fix = DW'(acc_q);
`endif

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state_q  <= S_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  // OP_WIDTH partial-product cycles, then one completion cycle that publishes RESULT.
  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    done_d   = done_q;
    if (clr_req) done_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_req) begin
          state_d  = S_RUN;
          mcand_d  = PW'(a_mag);
          mplier_d = b_mag;
          acc_d    = '0;
          cnt_d    = '0;
          done_d   = 1'b0;
        end
      end
      S_RUN: begin
        if (cnt_q == CW'(OP_WIDTH)) begin
          state_d  = S_IDLE;
          result_d = result_fix;
          done_d   = 1'b1;
        end else begin
          if (mplier_q[0]) acc_d = acc_q + mcand_q;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_axi_lite_mult_slave.sv
// Randomized self-checking bench for axi_lite_mult_slave against a register-level model.
module tb_axi_lite_mult_slave;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [3:0]  awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic        mult_done, mult_state;

  axi_lite_mult_slave dut (
    .S_AXI_ACLK   (clk),
    .S_AXI_ARESETN(rst_n),
    .S_AXI_AWADDR (awaddr),
    .S_AXI_AWPROT (awprot),
    .S_AXI_AWVALID(awvalid),
    .S_AXI_AWREADY(awready),
    .S_AXI_WDATA  (wdata),
    .S_AXI_WSTRB  (wstrb),
    .S_AXI_WVALID (wvalid),
    .S_AXI_WREADY (wready),
    .S_AXI_BRESP  (bresp),
    .S_AXI_BVALID (bvalid),
    .S_AXI_BREADY (bready),
    .S_AXI_ARADDR (araddr),
    .S_AXI_ARPROT (arprot),
    .S_AXI_ARVALID(arvalid),
    .S_AXI_ARREADY(arready),
    .S_AXI_RDATA  (rdata),
    .S_AXI_RRESP  (rresp),
    .S_AXI_RVALID (rvalid),
    .S_AXI_RREADY (rready),
    .mult_done_o  (mult_done),
    .mult_state_o (mult_state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  localparam int LAT = 17;
  logic [31:0] m_opa, m_opb, m_result, m_pend;
  logic        m_busy, m_done;
  int          m_done_cyc;
  int          last_wr_hs;

  function automatic logic [31:0] ref_product(input logic [31:0] a, input logic [31:0] b);
`ifdef AXI_LITE_MULT_SIGNED_EN
    longint sa, sb;
    logic [63:0] p;
    sa = longint'($signed(a[15:0]));
    sb = longint'($signed(b[15:0]));
    p  = 64'(sa * sb);
    return p[31:0];
`else
    logic [31:0] ua, ub;
    ua = {16'h0, a[15:0]};
    ub = {16'h0, b[15:0]};
    return ua * ub;
`endif
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] v,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old_v;
    for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = v[8*i +: 8];
    return r;
  endfunction

  task automatic model_reset();
    m_opa = 0; m_opb = 0; m_result = 0; m_pend = 0;
    m_busy = 0; m_done = 0; m_done_cyc = 0;
  endtask

  // State as seen after clock edge number c.
  task automatic model_advance(input int c);
    if (m_busy && c >= m_done_cyc) begin
      m_busy = 0; m_done = 1; m_result = m_pend;
    end
  endtask

  task automatic model_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int hs);
    model_advance(hs - 1);
    case (a[3:2])
      2'd0: m_opa = merge(m_opa, d, s);
      2'd1: m_opb = merge(m_opb, d, s);
      2'd2: if (s[0]) begin
        if (d[0] && !m_busy) begin
          m_busy = 1; m_done = 0;
          m_pend = ref_product(m_opa, m_opb);
          m_done_cyc = hs + LAT;
        end else if (d[1]) begin
          m_done = 0;
        end
      end
      default: ;
    endcase
  endtask

  function automatic logic [31:0] model_value(input logic [3:0] a);
    case (a[3:2])
      2'd0:    return m_opa;
      2'd1:    return m_opb;
      2'd2:    return {30'h0, m_done, m_busy};
      default: return m_result;
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int aw_lead, input int b_hold);
    int n;
    int hs;
    awaddr = a; awvalid = 1'b1;
    for (int i = 0; i < aw_lead; i++) begin
      @(posedge clk); #1;
      check_val("aw_only_no_ready", {30'h0, awready, wready}, 32'h0);
    end
    wdata = d; wstrb = s; wvalid = 1'b1;
    n = 0;
    while (!(awready && wready) && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check_val("wr_ready_seen", {31'h0, awready && wready}, 32'h1);
    @(posedge clk); #1;
    hs = cyc;
    last_wr_hs = hs;
    awvalid = 1'b0; wvalid = 1'b0;
    model_write(a, d, s, hs);
    check_val("wr_ready_pulse", {30'h0, awready, wready}, 32'h0);
    check_val("bvalid_rise", {31'h0, bvalid}, 32'h1);
    check_val("bresp", {30'h0, bresp}, 32'h0);
    for (int i = 0; i < b_hold; i++) begin
      @(posedge clk); #1;
      check_val("bvalid_hold", {29'h0, bvalid, awready, wready}, 32'h4);
    end
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
    check_val("bvalid_drop", {31'h0, bvalid}, 32'h0);
  endtask

  task automatic axi_read(input logic [3:0] a, input int r_hold, output logic [31:0] d);
    int n;
    int hs;
    araddr = a; arvalid = 1'b1;
    n = 0;
    while (!arready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check_val("ar_ready_seen", {31'h0, arready}, 32'h1);
    @(posedge clk); #1;
    hs = cyc;
    arvalid = 1'b0;
    model_advance(hs - 1);
    exp_q.push_back(model_value(a));
    check_val("rvalid_rise", {31'h0, rvalid}, 32'h1);
    check_val("rresp", {30'h0, rresp}, 32'h0);
    d = rdata;
    for (int i = 0; i < r_hold; i++) begin
      @(posedge clk); #1;
      check_val("rvalid_hold", {31'h0, rvalid}, 32'h1);
      check_val("rdata_hold", rdata, d);
    end
    rready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0;
    check_val("rvalid_drop", {31'h0, rvalid}, 32'h0);
    check_val($sformatf("rdata_addr%0h", a), d, exp_q.pop_front());
  endtask

  task automatic read_check(input logic [3:0] a);
    logic [31:0] d;
    axi_read(a, 0, d);
  endtask

  task automatic wait_done(input int start_hs, input string tag);
    int n;
    n = 0;
    while (!mult_done && n < 100) begin
      @(posedge clk); #1; n++;
    end
    check_val(tag, cyc - start_hs, LAT);
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b);
    int hs;
    axi_write(4'h0, a, 4'hF, 0, 0);
    axi_write(4'h4, b, 4'hF, 0, 0);
    axi_write(4'h8, 32'h1, 4'hF, 0, 0);
    hs = last_wr_hs;
    read_check(4'h8);
    wait_done(hs, "done_latency");
    read_check(4'h8);
    read_check(4'hC);
    axi_write(4'h8, 32'h2, 4'hF, 0, 0);
    check_val("done_cleared", {31'h0, mult_done}, 32'h0);
  endtask

  // ---------------- test sequence ----------------
  logic [31:0] d;
  int hs0;

  initial begin
    rst_n = 1'b0;
    awaddr = 0; awprot = 0; awvalid = 0; wdata = 0; wstrb = 0; wvalid = 0; bready = 0;
    araddr = 0; arprot = 0; arvalid = 0; rready = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_val("reset_outputs",
              {23'h0, awready, wready, bvalid, arready, rvalid, mult_done, mult_state, bresp},
              32'h0);
    check_val("reset_rdata", rdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) read_check(4'(i * 4));

    // Register readback, partial strobes, ignored low address bits
    axi_write(4'h0, 32'h0101FFFF, 4'hF, 0, 0);
    axi_write(4'h4, 32'hABCD0001, 4'hF, 0, 0);
    read_check(4'h0);
    read_check(4'h4);
    for (int i = 0; i < 4; i++) begin
      axi_write(4'h0 | 4'($urandom_range(0, 3)), $urandom, 4'($urandom_range(0, 15)), 0, 0);
      read_check(4'h0 | 4'($urandom_range(0, 3)));
    end

    // Basic multiply, W1C with DONE already clear
    run_op(32'h3, 32'h5);
    check_val("basic_result", m_result, 32'h0000000F);
    axi_write(4'h8, 32'h2, 4'hF, 0, 0);
    read_check(4'h8);

    // Max operands
`ifdef AXI_LITE_MULT_SIGNED_EN
    run_op(32'h0000FFFF, 32'h00000002);
    axi_read(4'hC, 0, d);
    check_val("max_result", d, 32'hFFFFFFFE);
    run_op(32'hFFFF8000, 32'h00008000);
`else
    run_op(32'h0000FFFF, 32'h0000FFFF);
    axi_read(4'hC, 0, d);
    check_val("max_result", d, 32'hFFFE0001);
`endif

    // Busy protection: OPA write and second START mid-run
    axi_write(4'h0, 32'h1234, 4'hF, 0, 0);
    axi_write(4'h4, 32'h0567, 4'hF, 0, 0);
    axi_write(4'h8, 32'h1, 4'hF, 0, 0);
    hs0 = last_wr_hs;
    axi_write(4'h0, 32'h7, 4'hF, 0, 0);
    axi_write(4'h8, 32'h1, 4'hF, 0, 0);
    wait_done(hs0, "busy_latency");
    read_check(4'hC);
    read_check(4'h0);
    check_val("busy_result", m_result, ref_product(32'h1234, 32'h0567));

    // START with clear bit in the same write: START wins
    axi_write(4'h4, 32'h9, 4'hF, 0, 0);
    axi_write(4'h8, 32'h3, 4'hF, 0, 0);
    hs0 = last_wr_hs;
    read_check(4'h8);
    wait_done(hs0, "start_clr_latency");
    read_check(4'hC);
    axi_write(4'h8, 32'h2, 4'hF, 0, 0);

    // Handshake stress
    axi_write(4'h4, $urandom, 4'hF, 3, 5);
    axi_read(4'h4, 4, d);
    axi_write(4'h0, $urandom, 4'h5, 2, 1);
    axi_read(4'h0, 2, d);

    // Randomized operations
    for (int i = 0; i < 6; i++) begin
      run_op($urandom, $urandom);
    end

    // RESULT write ignored, result held
    run_op(32'h20, 32'h30);
    axi_write(4'hC, $urandom, 4'hF, 0, 0);
    read_check(4'hC);

    // Reset asynchronously in the middle of a run
    axi_write(4'h0, 32'h1111, 4'hF, 0, 0);
    axi_write(4'h4, 32'h0003, 4'hF, 0, 0);
    axi_write(4'h8, 32'h1, 4'hF, 0, 0);
    read_check(4'h0);
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_val("midrst_outputs",
              {23'h0, awready, wready, bvalid, arready, rvalid, mult_done, mult_state, bresp},
              32'h0);
    check_val("midrst_rdata", rdata, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    read_check(4'h8);
    read_check(4'hC);
    read_check(4'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
